// File: rtl/spi_arbiter.sv
// Two-requester session arbiter for a shared SPI master (flash + RAM chip selects).
// Define SPI_ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed priority to requester 0.
module spi_arbiter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       r0_req,
   output logic       r0_gnt,
   input  logic [7:0] r0_data_tx,
   input  logic       r0_txn_start,
   input  logic       r0_force_clock,
   input  logic       r0_flash_ce_n,
   input  logic       r0_ram_ce_n,
   output logic       r0_txn_done,
   output logic [7:0] r0_data_rx,
   input  logic       r1_req,
   output logic       r1_gnt,
   input  logic [7:0] r1_data_tx,
   input  logic       r1_txn_start,
   input  logic       r1_force_clock,
   input  logic       r1_flash_ce_n,
   input  logic       r1_ram_ce_n,
   output logic       r1_txn_done,
   output logic [7:0] r1_data_rx,
   output logic [7:0] spi_data_tx,
   output logic       spi_txn_start,
   output logic       spi_force_clock,
   output logic       spi_flash_ce_n,
   output logic       spi_ram_ce_n,
   input  logic [7:0] spi_data_rx,
   input  logic       spi_txn_done
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GNT0    = 2'd1,
      GNT1    = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        busy_q, busy_d;
   logic        r0_gnt_q, r0_gnt_d;
   logic        r1_gnt_q, r1_gnt_d;
   logic [7:0]  spi_data_tx_q, spi_data_tx_d;
   logic        spi_txn_start_q, spi_txn_start_d;
   logic        spi_force_clock_q, spi_force_clock_d;
   logic        spi_flash_ce_n_q, spi_flash_ce_n_d;
   logic        spi_ram_ce_n_q, spi_ram_ce_n_d;

   logic        own_req_s;
   logic        own_start_s;
   logic [7:0]  own_data_s;
   logic        win1_s;
   logic        accept_s;
   logic        owned_next_s;

   // Select the current owner's request-side inputs; non-owner inputs never reach the bus.
   always_comb begin
      own_req_s   = 1'b0;
      own_start_s = 1'b0;
      own_data_s  = 8'h00;
      case (state_q)
         GNT0: begin
            own_req_s   = r0_req;
            own_start_s = r0_txn_start;
            own_data_s  = r0_data_tx;
         end
         GNT1: begin
            own_req_s   = r1_req;
            own_start_s = r1_txn_start;
            own_data_s  = r1_data_tx;
         end
         default: begin
            own_req_s   = 1'b0;
            own_start_s = 1'b0;
            own_data_s  = 8'h00;
         end
      endcase
   end

`ifdef SPI_ARB_ROUND_ROBIN_EN
   logic last_owner_q, last_owner_d;

   // Round-robin: on a tie the requester that did not own the bus most recently wins.
   always_comb begin
      win1_s = r1_req & (~r0_req | ~last_owner_q);
      if ((state_q == IDLE) && (state_d != IDLE)) begin
         last_owner_d = (state_d == GNT1);
      end else begin
         last_owner_d = last_owner_q;
      end
   end

   // Last-owner register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_owner_q <= 1'b1;
      end else begin
         last_owner_q <= last_owner_d;
      end
   end
`else
   // Fixed priority: the bootloader wins every tie.
   always_comb begin
      win1_s = r1_req & ~r0_req;
   end
`endif

   // Next-state logic; a release while busy waits for the in-flight done.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (r0_req | r1_req) begin
               state_d = win1_s ? GNT1 : GNT0;
            end else begin
               state_d = IDLE;
            end
         end
         GNT0, GNT1: begin
            if (!own_req_s && (!busy_q || spi_txn_done)) begin
               state_d = RELEASE;
            end else begin
               state_d = state_q;
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic: bus controls follow the owner of the coming cycle, idle values otherwise.
   always_comb begin
      owned_next_s     = (state_d == GNT0) || (state_d == GNT1);
      accept_s         = owned_next_s && (state_d == state_q) && own_start_s && !busy_q;
      spi_txn_start_d  = accept_s;
      spi_data_tx_d    = accept_s ? own_data_s : spi_data_tx_q;
      r0_gnt_d         = (state_d == GNT0);
      r1_gnt_d         = (state_d == GNT1);
      if (!owned_next_s) begin
         busy_d = 1'b0;
      end else if (accept_s) begin
         busy_d = 1'b1;
      end else if (spi_txn_done) begin
         busy_d = 1'b0;
      end else begin
         busy_d = busy_q;
      end
      case (state_d)
         GNT0: begin
            spi_flash_ce_n_d  = r0_flash_ce_n;
            spi_ram_ce_n_d    = r0_ram_ce_n;
            spi_force_clock_d = r0_force_clock;
         end
         GNT1: begin
            spi_flash_ce_n_d  = r1_flash_ce_n;
            spi_ram_ce_n_d    = r1_ram_ce_n;
            spi_force_clock_d = r1_force_clock;
         end
         default: begin
            spi_flash_ce_n_d  = 1'b1;
            spi_ram_ce_n_d    = 1'b1;
            spi_force_clock_d = 1'b0;
         end
      endcase
   end

   // State and registered-output flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q           <= IDLE;
         busy_q            <= 1'b0;
         r0_gnt_q          <= 1'b0;
         r1_gnt_q          <= 1'b0;
         spi_data_tx_q     <= 8'h00;
         spi_txn_start_q   <= 1'b0;
         spi_force_clock_q <= 1'b0;
         spi_flash_ce_n_q  <= 1'b1;
         spi_ram_ce_n_q    <= 1'b1;
      end else begin
         state_q           <= state_d;
         busy_q            <= busy_d;
         r0_gnt_q          <= r0_gnt_d;
         r1_gnt_q          <= r1_gnt_d;
         spi_data_tx_q     <= spi_data_tx_d;
         spi_txn_start_q   <= spi_txn_start_d;
         spi_force_clock_q <= spi_force_clock_d;
         spi_flash_ce_n_q  <= spi_flash_ce_n_d;
         spi_ram_ce_n_q    <= spi_ram_ce_n_d;
      end
   end

   assign r0_gnt          = r0_gnt_q;
   assign r1_gnt          = r1_gnt_q;
   assign spi_data_tx     = spi_data_tx_q;
   assign spi_txn_start   = spi_txn_start_q;
   assign spi_force_clock = spi_force_clock_q;
   assign spi_flash_ce_n  = spi_flash_ce_n_q;
   assign spi_ram_ce_n    = spi_ram_ce_n_q;

   // Completion is zero-latency and only reaches the current owner.
   assign r0_txn_done = spi_txn_done & (state_q == GNT0);
   assign r1_txn_done = spi_txn_done & (state_q == GNT1);
   assign r0_data_rx  = spi_data_rx;
   assign r1_data_rx  = spi_data_rx;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with an ownership-level reference model checked every cycle.
module tb_spi_arbiter;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       req[2], start[2], fclk_in[2], fce[2], rce[2];
   logic [7:0] dtx[2];
   logic       gnt[2], done[2];
   logic [7:0] drx[2];
   logic [7:0] spi_data_tx;
   logic       spi_txn_start, spi_force_clock, spi_flash_ce_n, spi_ram_ce_n;
   logic [7:0] spi_data_rx;
   logic       spi_txn_done;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   spi_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .r0_req(req[0]), .r0_gnt(gnt[0]), .r0_data_tx(dtx[0]), .r0_txn_start(start[0]),
      .r0_force_clock(fclk_in[0]), .r0_flash_ce_n(fce[0]), .r0_ram_ce_n(rce[0]),
      .r0_txn_done(done[0]), .r0_data_rx(drx[0]),
      .r1_req(req[1]), .r1_gnt(gnt[1]), .r1_data_tx(dtx[1]), .r1_txn_start(start[1]),
      .r1_force_clock(fclk_in[1]), .r1_flash_ce_n(fce[1]), .r1_ram_ce_n(rce[1]),
      .r1_txn_done(done[1]), .r1_data_rx(drx[1]),
      .spi_data_tx(spi_data_tx), .spi_txn_start(spi_txn_start),
      .spi_force_clock(spi_force_clock), .spi_flash_ce_n(spi_flash_ce_n),
      .spi_ram_ce_n(spi_ram_ce_n), .spi_data_rx(spi_data_rx), .spi_txn_done(spi_txn_done)
   );

   // Reference model: who owns the bus, whether we are in the one-cycle gap, and bus values.
   bit         m_has, m_id, m_rel, m_busy, m_start, m_fce, m_rce, m_fclk, m_last;
   logic [7:0] m_data;

   function automatic logic [1:0] m_pick();
      if (req[0] && req[1]) begin
`ifdef SPI_ARB_ROUND_ROBIN_EN
         return {1'b1, ~m_last};
`else
         return 2'b10;
`endif
      end else if (req[0]) begin
         return 2'b10;
      end else if (req[1]) begin
         return 2'b11;
      end else begin
         return 2'b00;
      end
   endfunction

   function automatic logic [1:0] m_next();
      if (m_rel) return 2'b00;
      if (!m_has) return m_pick();
      if (!req[m_id] && (!m_busy || spi_txn_done)) return 2'b00;
      return {1'b1, m_id};
   endfunction

   function automatic bit m_accept();
      return m_has && (m_next() == {1'b1, m_id}) && start[m_id] && !m_busy;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_has <= 1'b0; m_id <= 1'b0; m_rel <= 1'b0; m_busy <= 1'b0; m_start <= 1'b0;
         m_fce <= 1'b1; m_rce <= 1'b1; m_fclk <= 1'b0; m_last <= 1'b1; m_data <= 8'h00;
      end else begin
         m_has   <= m_next() >> 1;
         m_id    <= m_next() & 2'b01;
         m_rel   <= m_has && (m_next() == 2'b00);
         m_start <= m_accept();
         if (m_accept()) m_data <= dtx[m_id];
         m_busy  <= (m_has && m_next() == {1'b1, m_id}) ?
                    (m_accept() ? 1'b1 : (spi_txn_done ? 1'b0 : m_busy)) : 1'b0;
         m_fce   <= m_next() >> 1 ? fce[m_next() & 2'b01]     : 1'b1;
         m_rce   <= m_next() >> 1 ? rce[m_next() & 2'b01]     : 1'b1;
         m_fclk  <= m_next() >> 1 ? fclk_in[m_next() & 2'b01] : 1'b0;
         if (!m_has && !m_rel && (m_next() >> 1)) m_last <= m_next() & 2'b01;
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_r0_gnt", gnt[0], m_has && !m_id);
         chk("m_r1_gnt", gnt[1], m_has && m_id);
         chk("m_r0_done", done[0], spi_txn_done && m_has && !m_id);
         chk("m_r1_done", done[1], spi_txn_done && m_has && m_id);
         chk("m_r0_rx", drx[0], spi_data_rx);
         chk("m_r1_rx", drx[1], spi_data_rx);
         chk("m_start", spi_txn_start, m_start);
         chk("m_data", spi_data_tx, m_data);
         chk("m_fce", spi_flash_ce_n, m_fce);
         chk("m_rce", spi_ram_ce_n, m_rce);
         chk("m_fclk", spi_force_clock, m_fclk);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   bit tie_exp1;

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         req[i] = 1'b0; start[i] = 1'b0; fclk_in[i] = 1'b0;
         fce[i] = 1'b1; rce[i] = 1'b1; dtx[i] = 8'h00;
      end
      spi_data_rx = 8'h00;
      spi_txn_done = 1'b0;
      repeat (2) tick();
      chk("rst_gnt0", gnt[0], 1'b0);
      chk("rst_gnt1", gnt[1], 1'b0);
      chk("rst_fce", spi_flash_ce_n, 1'b1);
      chk("rst_rce", spi_ram_ce_n, 1'b1);
      chk("rst_start", spi_txn_start, 1'b0);
      chk("rst_data", spi_data_tx, 8'h00);
      chk("rst_fclk", spi_force_clock, 1'b0);
      chk_en = 1'b1;
      rst_n = 1'b1;
      tick();

      // Single owner r1 with a full transaction.
      req[1] = 1'b1; fce[1] = 1'b0; dtx[1] = 8'hA5;
      tick();
      chk("t1_gnt1", gnt[1], 1'b1);
      chk("t1_gnt0", gnt[0], 1'b0);
      chk("t1_fce", spi_flash_ce_n, 1'b0);
      start[1] = 1'b1;
      tick();
      start[1] = 1'b0;
      chk("t1_start", spi_txn_start, 1'b1);
      chk("t1_data", spi_data_tx, 8'hA5);
      tick();
      chk("t1_start_once", spi_txn_start, 1'b0);
      repeat (2) tick();
      spi_data_rx = 8'h3C; spi_txn_done = 1'b1;
      #1;
      chk("t1_done1", done[1], 1'b1);
      chk("t1_rx1", drx[1], 8'h3C);
      chk("t1_done0", done[0], 1'b0);
      tick();
      spi_txn_done = 1'b0;
      req[1] = 1'b0; fce[1] = 1'b1;
      tick();
      chk("t1_rel_gnt1", gnt[1], 1'b0);
      chk("t1_rel_fce", spi_flash_ce_n, 1'b1);
      repeat (2) tick();

      // Tie from idle, then release and re-grant gap.
      req[0] = 1'b1; req[1] = 1'b1;
      tick();
      chk("t2_tie_gnt0", gnt[0], 1'b1);
      chk("t2_tie_gnt1", gnt[1], 1'b0);
      tick();
      req[0] = 1'b0;
      tick();
      chk("t2_rel_gnt0", gnt[0], 1'b0);
      chk("t2_rel_gnt1", gnt[1], 1'b0);
      tick();
      chk("t2_idle_gnt1", gnt[1], 1'b0);
      tick();
      chk("t2_regrant_gnt1", gnt[1], 1'b1);
      req[1] = 1'b0;
      repeat (3) tick();
      req[0] = 1'b1; req[1] = 1'b1;
      tick();
      chk("t2_retie_gnt0", gnt[0], 1'b1);
      req[0] = 1'b0; req[1] = 1'b0;
      repeat (3) tick();
      req[0] = 1'b1; req[1] = 1'b1;
      tick();
`ifdef SPI_ARB_ROUND_ROBIN_EN
      tie_exp1 = 1'b1;
`else
      tie_exp1 = 1'b0;
`endif
      chk("t2_tie3_gnt1", gnt[1], tie_exp1);
      chk("t2_tie3_gnt0", gnt[0], !tie_exp1);
      req[0] = 1'b0; req[1] = 1'b0;
      repeat (3) tick();

      // Isolation: r0 owns, r1 pokes the bus.
      req[0] = 1'b1;
      tick();
      chk("t3_gnt0", gnt[0], 1'b1);
      req[1] = 1'b1; start[1] = 1'b1; rce[1] = 1'b0; fclk_in[1] = 1'b1; dtx[1] = 8'hEE;
      tick();
      start[1] = 1'b0;
      chk("t3_no_start", spi_txn_start, 1'b0);
      chk("t3_rce", spi_ram_ce_n, 1'b1);
      chk("t3_fclk", spi_force_clock, 1'b0);
      fclk_in[0] = 1'b1;
      tick();
      chk("t3_rce2", spi_ram_ce_n, 1'b1);
      chk("t3_own_fclk", spi_force_clock, 1'b1);
      fclk_in[0] = 1'b0;
      spi_txn_done = 1'b1;
      #1;
      chk("t3_done1", done[1], 1'b0);
      chk("t3_done0", done[0], 1'b1);
      tick();
      spi_txn_done = 1'b0;
      req[1] = 1'b0; rce[1] = 1'b1; fclk_in[1] = 1'b0;
      tick();

      // Release while busy, plus a dropped start.
      fce[0] = 1'b0; dtx[0] = 8'h5A; start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      chk("t4_start", spi_txn_start, 1'b1);
      chk("t4_data", spi_data_tx, 8'h5A);
      tick();
      start[0] = 1'b1; dtx[0] = 8'h11;
      tick();
      start[0] = 1'b0;
      chk("t4_busy_start", spi_txn_start, 1'b0);
      chk("t4_busy_data", spi_data_tx, 8'h5A);
      req[0] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t4_hold_gnt0", gnt[0], 1'b1);
      end
      chk("t4_hold_fce", spi_flash_ce_n, 1'b0);
      spi_data_rx = 8'h96; spi_txn_done = 1'b1;
      #1;
      chk("t4_done0", done[0], 1'b1);
      chk("t4_rx0", drx[0], 8'h96);
      tick();
      spi_txn_done = 1'b0;
      chk("t4_rel_gnt0", gnt[0], 1'b0);
      chk("t4_rel_fce", spi_flash_ce_n, 1'b1);
      chk("t4_rel_rce", spi_ram_ce_n, 1'b1);
      tick();
      chk("t4_idle_gnt0", gnt[0], 1'b0);
      chk("t4_idle_gnt1", gnt[1], 1'b0);
      fce[0] = 1'b1;
      tick();

      // Reset mid-transaction.
      req[0] = 1'b1; fce[0] = 1'b0;
      tick();
      dtx[0] = 8'h77; start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      chk("t5_start", spi_txn_start, 1'b1);
      #2;
      rst_n = 1'b0; req[0] = 1'b0; fce[0] = 1'b1;
      #1;
      chk("t5_rst_gnt0", gnt[0], 1'b0);
      chk("t5_rst_fce", spi_flash_ce_n, 1'b1);
      chk("t5_rst_rce", spi_ram_ce_n, 1'b1);
      chk("t5_rst_start", spi_txn_start, 1'b0);
      chk("t5_rst_data", spi_data_tx, 8'h00);
      tick();
      rst_n = 1'b1;
      tick();
      spi_txn_done = 1'b1;
      #1;
      chk("t5_late_done0", done[0], 1'b0);
      chk("t5_late_done1", done[1], 1'b0);
      tick();
      spi_txn_done = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
